// File: rtl/active_list_commit.sv
// active_list_commit
//   In-order retirement unit for the renamed register pipeline. It keeps a
//   circular active list of in-flight instructions:
//     - rename allocates entries at tail;
//     - writeback marks entries done by index;
//     - completed entries retire from head strictly in program order.
//   Each retirement remaps one architectural register and returns the
//   superseded physical register to the free list.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   global_flush              drop every in-flight entry
//   commit_stall              hold retirement for this cycle
//   alloc_*                   allocation request (alloc_ready and alloc_index are comb)
//   complete_valid/_index     completion report by active-list index
//   commit_*, free_*          registered one-cycle retirement pulse
//   count, empty              occupancy (count registered, empty comb)

`ifndef VREG_BUS
`define VREG_BUS 4:0
`endif
`ifndef PREG_BUS
`define PREG_BUS 5:0
`endif

module active_list_commit #(
  parameter int FREE_LIST_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       global_flush,
  input  logic                       commit_stall,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  output logic [FREE_LIST_WIDTH-1:0] alloc_index,
  input  logic                       alloc_wb_reg,
  input  logic [`VREG_BUS]           alloc_vreg,
  input  logic [`PREG_BUS]           alloc_preg_new,
  input  logic [`PREG_BUS]           alloc_preg_old,
  input  logic                       complete_valid,
  input  logic [FREE_LIST_WIDTH-1:0] complete_index,
  output logic                       commit_valid,
  output logic                       commit_wb_reg,
  output logic [`VREG_BUS]           commit_vreg,
  output logic [`PREG_BUS]           commit_preg,
  output logic                       free_valid,
  output logic [`PREG_BUS]           free_preg,
  output logic [FREE_LIST_WIDTH:0]   count,
  output logic                       empty
);

  localparam int FW    = FREE_LIST_WIDTH;
  localparam int DEPTH = 1 << FW;
  localparam logic [FW:0] DEPTH_C = (FW+1)'(DEPTH);

  // Entry storage, one slot per list position.
  logic [DEPTH-1:0]                  e_valid;
  logic [DEPTH-1:0]                  e_done;
  logic [DEPTH-1:0]                  e_wb_reg;
  logic [DEPTH-1:0][`VREG_BUS]       e_vreg;
  logic [DEPTH-1:0][`PREG_BUS]       e_preg_new;
  logic [DEPTH-1:0][`PREG_BUS]       e_preg_old;

  logic [FW-1:0] head, tail;
  logic          alloc_fire, complete_fire, retire_fire;

  assign alloc_ready   = (count != DEPTH_C);
  assign alloc_index   = tail;
  assign empty         = (count == '0);

  // Flush wins over everything; full is judged on the current count only,
  // so a retirement in the same cycle cannot open a slot for allocation.
  assign alloc_fire    = alloc_valid & alloc_ready & ~global_flush;
  assign complete_fire = complete_valid & e_valid[complete_index] & ~global_flush;
  // Uses the registered done bit: a completion aimed at head this cycle
  // only makes it retire-eligible on the next cycle.
  assign retire_fire   = e_valid[head] & e_done[head] & ~commit_stall & ~global_flush;

  // Per-entry state. Allocation and retirement never address the same slot
  // in one cycle (alloc needs a free slot, retire needs a valid one).
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [FW-1:0] IDX = FW'(i);
    logic wr, set_done, clr;
    assign wr       = alloc_fire    & (tail == IDX);
    assign set_done = complete_fire & (complete_index == IDX);
    assign clr      = retire_fire   & (head == IDX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        e_valid[i]    <= 1'b0;
        e_done[i]     <= 1'b0;
        e_wb_reg[i]   <= 1'b0;
        e_vreg[i]     <= '0;
        e_preg_new[i] <= '0;
        e_preg_old[i] <= '0;
      end else if (global_flush) begin
        e_valid[i] <= 1'b0;
        e_done[i]  <= 1'b0;
      end else if (wr) begin
        e_valid[i]    <= 1'b1;
        e_done[i]     <= 1'b0;
        e_wb_reg[i]   <= alloc_wb_reg;
        e_vreg[i]     <= alloc_vreg;
        e_preg_new[i] <= alloc_preg_new;
        e_preg_old[i] <= alloc_preg_old;
      end else if (clr) begin
        // A late duplicate completion must not resurrect a retiring slot.
        e_valid[i] <= 1'b0;
        e_done[i]  <= 1'b0;
      end else if (set_done) begin
        e_done[i] <= 1'b1;
      end
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (global_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (alloc_fire)  tail <= tail + 1'b1;
      if (retire_fire) head <= head + 1'b1;
      case ({alloc_fire, retire_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Retirement outputs: single-cycle registered pulse per retired entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid  <= 1'b0;
      commit_wb_reg <= 1'b0;
      commit_vreg   <= '0;
      commit_preg   <= '0;
      free_valid    <= 1'b0;
      free_preg     <= '0;
    end else begin
      commit_valid <= retire_fire;
      free_valid   <= retire_fire & e_wb_reg[head];
      if (retire_fire) begin
        commit_wb_reg <= e_wb_reg[head];
        commit_vreg   <= e_vreg[head];
        commit_preg   <= e_preg_new[head];
        free_preg     <= e_preg_old[head];
      end
    end
  end

endmodule

// File: doc/active_list_commit.md
# active_list_commit

In-order retirement unit for the renamed register pipeline. It holds a circular active list of in-flight instructions: decode/rename allocates entries, and the memory-to-writeback stage marks them complete by active-list index. The unit then retires completed entries strictly in program order. Each retirement updates the architectural map and returns the superseded physical register to the free list.

## Interface
Parameters:
- FREE_LIST_WIDTH, 3, index width; list depth DEPTH = 2^FREE_LIST_WIDTH (8)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- global_flush  in  1  discard all entries (exception/redirect)
- commit_stall  in  1  inhibit retirement this cycle
- alloc_valid  in  1  rename requests an entry
- alloc_ready  out  1  combinational, = (count != DEPTH)
- alloc_index  out  FREE_LIST_WIDTH  combinational, = tail; index given to the allocated instruction
- alloc_wb_reg  in  1  instruction writes a register
- alloc_vreg  in  `VREG_BUS  architectural destination
- alloc_preg_new  in  `PREG_BUS  newly mapped physical destination
- alloc_preg_old  in  `PREG_BUS  previous mapping of alloc_vreg
- complete_valid  in  1  writeback stage reports completion
- complete_index  in  FREE_LIST_WIDTH  active-list index being completed
- commit_valid  out  1  registered, one retirement this cycle
- commit_wb_reg  out  1  registered, retired entry writes a register
- commit_vreg  out  `VREG_BUS  registered, architectural register to remap
- commit_preg  out  `PREG_BUS  registered, new committed physical register
- free_valid  out  1  registered, = commit_valid & commit_wb_reg
- free_preg  out  `PREG_BUS  registered, old physical register returned to free list
- count  out  FREE_LIST_WIDTH+1  registered occupancy
- empty  out  1  combinational, = (count == 0)

## Operation
- Storage per entry: valid, done, wb_reg, vreg, preg_new, preg_old. head and tail pointers are FREE_LIST_WIDTH bits and wrap modulo DEPTH naturally.
- Allocate: fires when alloc_valid & alloc_ready & !global_flush.
  - entry[tail] is written with valid=1, done=0 and the input fields.
  - tail increments.
- Complete: fires when complete_valid & entry[complete_index].valid & !global_flush.
  - Sets entry[complete_index].done=1.
  - Completion of an invalid entry is ignored, with no state change.
  - Repeated completion of the same entry is harmless.
- Retire: fires when entry[head].valid & entry[head].done & !commit_stall & !global_flush.
  - commit_* and free_preg are loaded from entry[head].
  - entry[head].valid and done are cleared; head increments.
  - At most one retirement per cycle.
- count' = count + alloc_fire − retire_fire. count never exceeds DEPTH and never underflows.
- Full boundary: alloc_ready is based on the current count only. A retirement in the same cycle does not permit allocation when count == DEPTH.
- Empty boundary: nothing retires; commit_valid = 0.
- Allocate, complete and retire may all fire in the same cycle on different entries.
- A completion targeting head in the same cycle does not retire that cycle. done becomes visible on the next cycle.
- global_flush has top priority:
  - All valid/done bits, head, tail and count go to 0.
  - commit_valid and free_valid go to 0.
  - Simultaneous alloc, complete and retire are suppressed.
- commit_stall holds head and the entries. commit_valid/free_valid drop to 0 for that cycle; allocation and completion continue.

## Timing
- Reset (rst high, asynchronous) clears:
  - all entries, head, tail and count to 0;
  - commit_valid, commit_wb_reg, commit_vreg, commit_preg, free_valid and free_preg to 0.
- Resulting combinational values: alloc_ready=1, alloc_index=0, empty=1.
- Reset asserted mid-operation discards all in-flight entries, with no retirement output.
- Allocate at edge N: the entry is valid after N, and alloc_index has advanced after N.
- Completion at edge N: done=1 after N. If the entry is at head and unstalled, it retires at edge N+1, so commit_valid is high during cycle N+1→N+2.
- Minimum alloc→commit latency is 2 edges: allocate at N, complete at N+1, commit registered at N+2.
- Sustained throughput: one allocation and one retirement per cycle.
- commit_* outputs are registered pulses lasting exactly one cycle per retirement.

## Test plan
- Reset then single flow:
  - Allocate vreg=3, preg_new=10, preg_old=4 with wb_reg=1; expect alloc_index=0.
  - Complete index 0 the next cycle.
  - Expect one cycle later: commit_valid=1, commit_vreg=3, commit_preg=10, free_valid=1, free_preg=4, count=0.
- Out-of-order completion:
  - Allocate 3 entries (indices 0,1,2); complete 2, then 1, then 0.
  - Expect no commit until 0 completes, then commits in order 0,1,2 on consecutive cycles.
- Full/wrap:
  - Allocate 8 entries; expect alloc_ready=0, count=8.
  - Retire one while alloc_valid is held high; expect no allocation that cycle and alloc_ready=1 the next.
  - Then allocate; expect alloc_index=0, i.e. wrapped.
- Stall and non-writing entry:
  - Entry with wb_reg=0 completed while commit_stall=1; expect no commit.
  - Release the stall; expect commit_valid=1, free_valid=0.
- Flush:
  - With 5 entries (2 done), assert global_flush together with alloc_valid and complete_valid.
  - Expect count=0, empty=1, no commit, alloc_index=0 next cycle.
- Async reset mid-run:
  - Assert rst between edges with count=4.
  - Expect outputs cleared immediately without waiting for a clock edge, and no commit after release.
